// File: rtl/adc_drive_ctrl_pkg.sv
// Shared types and arithmetic helpers for the ADC-scan / differential-drive controller.
package adc_drive_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETCH,
        ST_START,
        ST_WAIT,
        ST_LATCH,
        ST_NEXT
    } seq_state_t;

    typedef enum logic [1:0] {
        DIR_STOP,
        DIR_FWD,
        DIR_REV,
        DIR_COAST
    } dir_t;

    // Working width for mix/magnitude arithmetic; comfortably wider than PWM_W+1.
    localparam int MW = 16;

    function automatic logic signed [MW-1:0] sat_s(input logic signed [MW-1:0] v,
                                                   input logic signed [MW-1:0] lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic logic [MW-1:0] abs_s(input logic signed [MW-1:0] v);
        return v[MW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic is_flip(input dir_t a, input dir_t b);
        return ((a == DIR_FWD) && (b == DIR_REV)) || ((a == DIR_REV) && (b == DIR_FWD));
    endfunction

endpackage

// File: rtl/adc_drive_ctrl_if.sv
// ADC conversion port: channel select, power-down and the soc/eoc conversion handshake.
// Handshake: the controller holds s stable, raises soc for one sequencer tick; the ADC later
// raises eoc (a 0->1 edge) and keeps dout valid while eoc is high. eoc already high is not a response.
interface adc_drive_ctrl_if #(
    parameter int ADC_W = 12,
    parameter int CH_W  = 3
);
    logic             eoc;
    logic [ADC_W-1:0] dout;
    logic             soc;
    logic             pd;
    logic [CH_W-1:0]  s;

    modport master (input eoc, input dout, output soc, output pd, output s);
    modport slave  (output eoc, output dout, input soc, input pd, input s);
endinterface

// File: rtl/adc_drive_ctrl_motor_chan.sv
// One motor channel: command register, PWM compare against the shared counter, and
// direction FSM that coasts for DEADTIME PWM periods on every reversal.
module adc_drive_ctrl_motor_chan
    import adc_drive_ctrl_pkg::*;
#(
    parameter int PWM_W    = 8,
    parameter int DEADTIME = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_vld,
    input  logic signed [MW-1:0] cmd_m,
    input  logic [PWM_W-1:0]     pwm_cnt,
    input  logic                 cnt_wrap,
    output logic                 pwm,
    output logic                 in1,
    output logic                 in2
);
    localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [MW-1:0] DMAX = MW'(2**PWM_W - 1);

    logic [PWM_W-1:0] duty_q, duty_d, duty_act_q, duty_act_d, duty_new;
    dir_t             req_q, req_d, req_new;
    dir_t             dir_q, dir_d, pend_q, pend_d;
    logic [DT_W-1:0]  dt_q, dt_d;
    logic             pwm_q, pwm_d, in1_q, in1_d, in2_q, in2_d;
    logic [MW-1:0]    mag, dbl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q     <= '0;
            duty_act_q <= '0;
            req_q      <= DIR_STOP;
            dir_q      <= DIR_STOP;
            pend_q     <= DIR_STOP;
            dt_q       <= '0;
            pwm_q      <= 1'b0;
            in1_q      <= 1'b0;
            in2_q      <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            duty_act_q <= duty_act_d;
            req_q      <= req_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            dt_q       <= dt_d;
            pwm_q      <= pwm_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
        end
    end

    always_comb begin
        mag      = abs_s(cmd_m);
        dbl      = mag << 1;
        duty_new = (dbl > DMAX) ? DMAX[PWM_W-1:0] : dbl[PWM_W-1:0];
        if (cmd_m == '0) req_new = DIR_STOP;
        else if (cmd_m[MW-1]) req_new = DIR_REV;
        else req_new = DIR_FWD;
        duty_d = cmd_vld ? duty_new : duty_q;
        req_d  = cmd_vld ? req_new : req_q;
    end

    // Direction and duty only change on counter wrap, so coast spans whole PWM periods.
    always_comb begin
        dir_d      = dir_q;
        pend_d     = pend_q;
        dt_d       = dt_q;
        duty_act_d = duty_act_q;
        if (cnt_wrap) begin
            duty_act_d = duty_q;
            if (dir_q == DIR_COAST) begin
                pend_d = req_q;
                if (is_flip(pend_q, req_q)) dt_d = '0;
                else if (dt_q == DT_W'(DEADTIME - 1)) dir_d = req_q;
                else dt_d = dt_q + DT_W'(1);
            end else if (is_flip(dir_q, req_q)) begin
                dir_d  = DIR_COAST;
                pend_d = req_q;
                dt_d   = '0;
            end else begin
                dir_d = req_q;
            end
        end
    end

    always_comb begin
        pwm_d = ((dir_q == DIR_FWD) || (dir_q == DIR_REV)) && (pwm_cnt < duty_act_q);
        in1_d = (dir_q == DIR_FWD);
        in2_d = (dir_q == DIR_REV);
    end

    assign pwm = pwm_q;
    assign in1 = in1_q;
    assign in2 = in2_q;

endmodule

// File: rtl/adc_drive_ctrl.sv
// Scans NUM_CH ADC channels, turns the throttle/steering axes into a saturating
// differential mix and drives two H-bridge channels from a shared PWM counter.
module adc_drive_ctrl
    import adc_drive_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 3,
    parameter int ADC_W      = 12,
    parameter int PWM_W      = 8,
    parameter int CH_Y       = 0,
    parameter int CH_X       = 1,
    parameter int DEAD       = 16,
    parameter int PWRUP_TK   = 100,
    parameter int TIMEOUT_TK = 255,
    parameter int DEADTIME   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    adc_drive_ctrl_if.master  adc,
    output logic              frame_vld,
    output logic              adc_timeout,
    output logic              pwm_left,
    output logic              pwm_right,
    output logic              in1_left,
    output logic              in2_left,
    output logic              in1_right,
    output logic              in2_right
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TK_MAX = (PWRUP_TK > TIMEOUT_TK) ? PWRUP_TK : TIMEOUT_TK;
    localparam int TK_W   = $clog2(TK_MAX + 1);
    localparam logic [ADC_W-1:0] CENTRE = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic signed [PWM_W-1:0] DEAD_V = PWM_W'(DEAD);
    localparam logic signed [MW-1:0] LIM = MW'(2**(PWM_W-1) - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic             eoc_s1_q, eoc_s2_q, eoc_s3_q, eoc_rise;
    seq_state_t       state_q, state_d;
    logic [TK_W-1:0]  tk_q, tk_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             rise_pend_q, rise_pend_d;
    logic [ADC_W-1:0] sample_q [NUM_CH];
    logic [ADC_W-1:0] sample_d [NUM_CH];
    logic             soc_q, soc_d, pd_q, pd_d, frame_vld_q, frame_vld_d, timeout_q, timeout_d;
    logic [CH_W-1:0]  s_q, s_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic signed [PWM_W-1:0] v_y, v_x;
    logic signed [MW-1:0]    y_w, x_w, l_w, r_w;
    logic             unused_lsbs;

    // Offset-binary top bits to signed, then zero the centre dead zone.
    function automatic logic signed [PWM_W-1:0] axis_val(input logic [PWM_W-1:0] u);
        logic signed [PWM_W-1:0] v;
        v = $signed({~u[PWM_W-1], u[PWM_W-2:0]});
        if ((v < DEAD_V) && (v > -DEAD_V)) v = '0;
        return v;
    endfunction

    assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
    assign eoc_rise = eoc_s2_q & ~eoc_s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            eoc_s1_q    <= 1'b0;
            eoc_s2_q    <= 1'b0;
            eoc_s3_q    <= 1'b0;
            state_q     <= ST_PWRUP;
            tk_q        <= '0;
            ch_q        <= '0;
            rise_pend_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) sample_q[i] <= CENTRE;
            soc_q       <= 1'b0;
            pd_q        <= 1'b1;
            s_q         <= '0;
            frame_vld_q <= 1'b0;
            timeout_q   <= 1'b0;
            pwm_cnt_q   <= '0;
        end else begin
            div_q       <= div_d;
            eoc_s1_q    <= adc.eoc;
            eoc_s2_q    <= eoc_s1_q;
            eoc_s3_q    <= eoc_s2_q;
            state_q     <= state_d;
            tk_q        <= tk_d;
            ch_q        <= ch_d;
            rise_pend_q <= rise_pend_d;
            sample_q    <= sample_d;
            soc_q       <= soc_d;
            pd_q        <= pd_d;
            s_q         <= s_d;
            frame_vld_q <= frame_vld_d;
            timeout_q   <= timeout_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

    // A rise seen any clock during WAIT is held until the next sequencer tick.
    always_comb begin
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        pwm_cnt_d   = pwm_cnt_q + PWM_W'(1);
        state_d     = state_q;
        tk_d        = tk_q;
        ch_d        = ch_q;
        sample_d    = sample_q;
        timeout_d   = timeout_q;
        rise_pend_d = (state_q == ST_WAIT) && (rise_pend_q || eoc_rise);
        if (tick) begin
            unique case (state_q)
                ST_PWRUP: begin
                    if (tk_q == TK_W'(PWRUP_TK - 1)) begin
                        state_d = ST_SETCH;
                        tk_d    = '0;
                    end else begin
                        tk_d = tk_q + TK_W'(1);
                    end
                end
                ST_SETCH: state_d = ST_START;
                ST_START: begin
                    state_d = ST_WAIT;
                    tk_d    = '0;
                end
                ST_WAIT: begin
                    if (rise_pend_q || eoc_rise) begin
                        state_d = ST_LATCH;
                    end else if (tk_q == TK_W'(TIMEOUT_TK - 1)) begin
                        state_d   = ST_NEXT;
                        timeout_d = 1'b1;
                    end else begin
                        tk_d = tk_q + TK_W'(1);
                    end
                end
                ST_LATCH: begin
                    for (int i = 0; i < NUM_CH; i++)
                        if (ch_q == CH_W'(i)) sample_d[i] = adc.dout;
                    state_d = ST_NEXT;
                end
                ST_NEXT: begin
                    ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                    state_d = ST_SETCH;
                end
                default: state_d = ST_PWRUP;
            endcase
        end
    end

    always_comb begin
        soc_d       = (state_d == ST_START);
        pd_d        = 1'b0;
        s_d         = ch_d;
        frame_vld_d = tick && (state_q == ST_NEXT) && (ch_q == CH_W'(NUM_CH - 1));
    end

    always_comb begin
        v_y = axis_val(sample_q[CH_Y][ADC_W-1 -: PWM_W]);
        v_x = axis_val(sample_q[CH_X][ADC_W-1 -: PWM_W]);
        y_w = MW'(v_y);
        x_w = MW'(v_x);
        l_w = sat_s(y_w + x_w, LIM);
        r_w = sat_s(y_w - x_w, LIM);
        unused_lsbs = 1'b0;
        for (int i = 0; i < NUM_CH; i++) unused_lsbs = unused_lsbs ^ (^sample_q[i]);
    end

    adc_drive_ctrl_motor_chan #(.PWM_W(PWM_W), .DEADTIME(DEADTIME)) u_left (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_vld  (frame_vld_q),
        .cmd_m    (l_w),
        .pwm_cnt  (pwm_cnt_q),
        .cnt_wrap (pwm_cnt_q == '1),
        .pwm      (pwm_left),
        .in1      (in1_left),
        .in2      (in2_left)
    );

    adc_drive_ctrl_motor_chan #(.PWM_W(PWM_W), .DEADTIME(DEADTIME)) u_right (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_vld  (frame_vld_q),
        .cmd_m    (r_w),
        .pwm_cnt  (pwm_cnt_q),
        .cnt_wrap (pwm_cnt_q == '1),
        .pwm      (pwm_right),
        .in1      (in1_right),
        .in2      (in2_right)
    );

    assign adc.soc     = soc_q;
    assign adc.pd      = pd_q;
    assign adc.s       = s_q;
    assign frame_vld   = frame_vld_q;
    assign adc_timeout = timeout_q;

endmodule

// File: tb/tb_adc_drive_ctrl.sv
// Directed bench for adc_drive_ctrl: behavioural ADC responder plus hand-computed drive checks.
module tb_adc_drive_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_vld, adc_timeout, pwm_left, pwm_right, in1_left, in2_left, in1_right, in2_right;
    logic [11:0] y_val, x_val;
    bit adc_en;
    int vectors = 0;
    int miscompares = 0;

    adc_drive_ctrl_if #(.ADC_W(12), .CH_W(3)) adc ();

    adc_drive_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adc         (adc),
        .frame_vld   (frame_vld),
        .adc_timeout (adc_timeout),
        .pwm_left    (pwm_left),
        .pwm_right   (pwm_right),
        .in1_left    (in1_left),
        .in2_left    (in2_left),
        .in1_right   (in1_right),
        .in2_right   (in2_right)
    );

    always #5 clk = ~clk;

    // ADC model: drop eoc on soc, answer a few clocks after soc falls when enabled.
    initial begin
        forever begin
            @(posedge adc.soc);
            adc.eoc = 1'b0;
            if (adc_en) begin
                @(negedge adc.soc);
                repeat (3) @(negedge clk);
                adc.dout = (adc.s == 3'd0) ? y_val : x_val;
                adc.eoc  = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_frame(input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (frame_vld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_soc(input logic lvl, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            if (adc.soc === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic drive_case(input string tag, input logic [11:0] yv, input logic [11:0] xv,
                              input logic [1:0] exp_l, input logic [1:0] exp_r,
                              input int dl, input int dr);
        bit ok1, ok2;
        int nl, nr;
        y_val = yv;
        x_val = xv;
        wait_frame(5000, ok1);
        wait_frame(5000, ok2);
        chk({tag, "_frames"}, {ok1, ok2}, 2'b11);
        repeat (600) @(negedge clk);
        nl = 0;
        nr = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm_left) nl++;
            if (pwm_right) nr++;
        end
        chk({tag, "_dir_l"}, {in1_left, in2_left}, exp_l);
        chk({tag, "_dir_r"}, {in1_right, in2_right}, exp_r);
        chk({tag, "_duty_l"}, nl, dl);
        chk({tag, "_duty_r"}, nr, dr);
    endtask

    initial begin
        bit ok;
        int n, pw;
        logic [2:0] s_at;
        adc.eoc  = 1'b0;
        adc.dout = '0;
        y_val    = 12'h800;
        x_val    = 12'h800;
        adc_en   = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_pd", adc.pd, 1);
        chk("rst_soc", adc.soc, 0);
        chk("rst_s", adc.s, 0);
        chk("rst_frame_vld", frame_vld, 0);
        chk("rst_timeout", adc_timeout, 0);
        chk("rst_drive", {pwm_left, pwm_right, in1_left, in2_left, in1_right, in2_right}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("pwrup_pd", adc.pd, 0);

        // NUM_CH conversions per frame
        wait_frame(10000, ok);
        chk("first_frame", ok, 1);
        n = 0;
        ok = 1'b0;
        begin
            logic prev;
            prev = adc.soc;
            for (int i = 0; i < 5000; i++) begin
                @(negedge clk);
                if (adc.soc && !prev) n++;
                prev = adc.soc;
                if (frame_vld) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        chk("socs_per_frame", n, 2);
        chk("second_frame", ok, 1);

        drive_case("centre",    12'h800, 12'h800, 2'b00, 2'b00, 0, 0);
        drive_case("fwd",       12'hFFF, 12'h800, 2'b10, 2'b10, 254, 254);
        drive_case("mix_sat",   12'hFFF, 12'hFFF, 2'b10, 2'b00, 254, 0);
        drive_case("dead_zone", 12'h880, 12'h800, 2'b00, 2'b00, 0, 0);
        drive_case("fwd2",      12'hFFF, 12'h800, 2'b10, 2'b10, 254, 254);

        // Reversal: exactly 4 PWM periods of coast
        y_val = 12'h000;
        n = 0;
        while (in1_left && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("flip_left_fwd", in1_left, 0);
        n = 0;
        pw = 0;
        while (!in2_left && n < 3000) begin
            if (pwm_left || in1_left) pw++;
            n++;
            @(negedge clk);
        end
        chk("coast_len", n, 1024);
        chk("coast_pwm_low", pw, 0);
        chk("flip_right_rev", {in1_right, in2_right}, 2'b01);

        drive_case("rev",     12'h000, 12'h800, 2'b01, 2'b01, 254, 254);
        drive_case("rev_mix", 12'h000, 12'hFFF, 2'b01, 2'b01, 2, 254);

        // ADC silent: timeout after 255 ticks of WAIT
        adc_en = 1'b0;
        wait_soc(1'b0, 500, ok);
        wait_soc(1'b1, 2000, ok);
        wait_soc(1'b0, 200, ok);
        chk("to_wait_entry", ok, 1);
        n = 0;
        while (!adc_timeout && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, 12750);
        s_at = adc.s;
        repeat (200) @(negedge clk);
        chk("to_s_next", adc.s, (s_at == 3'd1) ? 3'd0 : 3'd1);
        wait_frame(30000, ok);
        chk("to_frame_vld", ok, 1);
        chk("to_sticky", adc_timeout, 1);
        chk("to_hold_left", {in1_left, in2_left}, 2'b01);

        // Reset in the middle of WAIT
        wait_soc(1'b1, 20000, ok);
        wait_soc(1'b0, 200, ok);
        chk("midrst_in_wait", ok, 1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_pd", adc.pd, 1);
        chk("midrst_soc_s", {adc.soc, adc.s}, 0);
        chk("midrst_flags", {frame_vld, adc_timeout}, 0);
        chk("midrst_drive", {pwm_left, pwm_right, in1_left, in2_left, in1_right, in2_right}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        adc_en = 1'b1;
        n = 0;
        while (!adc.soc && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk("restart_latency", n, 5050);
        chk("restart_ch0", adc.s, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
